// File: rtl/ahb_ram_pkg.sv
// -----------------------------------------------------------------------------
// ahb_ram_pkg
// Shared constants and helpers for the AHB-Lite slave data-memory RAM.
//   BYTE_W      : width of one byte lane
//   MAX_DATA_W  : widest data word the helpers accept
//   be_merge()  : byte-lane merge of a new word over an old word
// -----------------------------------------------------------------------------
package ahb_ram_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

    // Bytes whose enable bit is set come from new_word, all others from old_word.
    // Callers zero-extend narrower words and truncate the result.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// -----------------------------------------------------------------------------
// dp_ram_core
// Bare simple-dual-port storage: one byte-enable write port, one registered
// read port, single clock. No range checking; written to map onto block RAM.
// Read-during-write to the same address returns the old contents.
// Ports:
//   CLK    clock, rising edge
//   we     write strobe
//   waddr  write word address
//   wdata  write data
//   wbe    byte enables, bit i covers wdata[8i+7:8i]
//   re     read strobe; rdata only changes when re=1
//   raddr  read word address
//   rdata  registered read data (no reset)
// -----------------------------------------------------------------------------
module dp_ram_core
    import ahb_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] wbe,
    input  logic                     re,
    input  logic [AW-1:0]            raddr,
    output logic [DATA_W-1:0]        rdata
);

    localparam int BE_W = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dp_ram_be.sv
// -----------------------------------------------------------------------------
// dp_ram_be
// Simple dual-port RAM with byte-enable writes, range checking and a 1- or
// 2-cycle read pipeline with valid strobe. Backing store for AHB-Lite slave
// data memories.
// Optional feature macro: DP_RAM_BYPASS_EN
//   defined   : same-cycle same-address READ+WRITE returns the merged new data
//   undefined : such a read returns the contents before the write
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous reset, active-low
//   WRITE     write request
//   WR_ADDR   write word address (full width is range checked)
//   WR_DATA   write data
//   WR_BE     byte enables
//   WR_ERR    one-cycle pulse: previous-cycle write was out of range
//   READ      read request, one accepted per cycle
//   RD_ADDR   read word address (full width is range checked)
//   RD_DATA   read data, held while RD_VALID=0
//   RD_VALID  pulse 1+OUT_REG cycles after READ
//   RD_ERR    qualifies RD_VALID: read was out of range, RD_DATA=0
// -----------------------------------------------------------------------------
module dp_ram_be
    import ahb_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WRITE,
    input  logic [ADDR_W-1:0]        WR_ADDR,
    input  logic [DATA_W-1:0]        WR_DATA,
    input  logic [DATA_W/BYTE_W-1:0] WR_BE,
    output logic                     WR_ERR,
    input  logic                     READ,
    input  logic [ADDR_W-1:0]        RD_ADDR,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic                     RD_VALID,
    output logic                     RD_ERR
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable even when ADDR_W is tight.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rd_pipe_t;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] core_rdata;
    logic [DATA_W-1:0] rd_word_p0;
    logic              vld_p0;
    logic              zero_p0;
    logic              wr_err_p0;
    rd_pipe_t          pipe_p0;
    rd_pipe_t          rd_out;

    assign wr_in_range = ({1'b0, WR_ADDR} < DEPTH_X);
    assign rd_in_range = ({1'b0, RD_ADDR} < DEPTH_X);

    dp_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_core (
        .CLK   (CLK),
        .we    (WRITE & wr_in_range),
        .waddr (WR_ADDR[AW-1:0]),
        .wdata (WR_DATA),
        .wbe   (WR_BE),
        .re    (READ & rd_in_range),
        .raddr (RD_ADDR[AW-1:0]),
        .rdata (core_rdata)
    );

    // ---- stage p0: request sampled, core read register loaded ----
    // zero_p0 forces RD_DATA to 0 after reset and after an out-of-range read;
    // it is only updated on accepted reads so RD_DATA holds between reads.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_p0    <= 1'b0;
            zero_p0   <= 1'b1;
            wr_err_p0 <= 1'b0;
        end else begin
            vld_p0    <= READ;
            wr_err_p0 <= WRITE & ~wr_in_range;
            if (READ) begin
                zero_p0 <= ~rd_in_range;
            end
        end
    end

`ifdef DP_RAM_BYPASS_EN
    logic              coll;
    logic              coll_p0;
    logic [DATA_W-1:0] byp_data_p0;
    logic [DATA_W/BYTE_W-1:0] byp_be_p0;

    assign coll = WRITE & READ & wr_in_range & rd_in_range & (WR_ADDR == RD_ADDR);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            coll_p0 <= 1'b0;
        end else if (READ) begin
            coll_p0 <= coll;
        end
    end

    always_ff @(posedge CLK) begin
        if (READ && coll) begin
            byp_data_p0 <= WR_DATA;
            byp_be_p0   <= WR_BE;
        end
    end

    // The core is read-first; overlaying the captured write bytes gives write-first.
    always_comb begin
        rd_word_p0 = core_rdata;
        if (coll_p0) begin
            rd_word_p0 = DATA_W'(be_merge(MAX_DATA_W'(core_rdata),
                                          MAX_DATA_W'(byp_data_p0),
                                          MAX_BE_W'(byp_be_p0)));
        end
    end
`else
    assign rd_word_p0 = core_rdata;
`endif

    always_comb begin
        pipe_p0.valid = vld_p0;
        pipe_p0.err   = vld_p0 & zero_p0;
        pipe_p0.data  = zero_p0 ? '0 : rd_word_p0;
    end

    // ---- stage p1: optional output register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            rd_pipe_t pipe_p1;

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    pipe_p1.valid <= 1'b0;
                    pipe_p1.err   <= 1'b0;
                    pipe_p1.data  <= '0;
                end else begin
                    pipe_p1.valid <= pipe_p0.valid;
                    pipe_p1.err   <= pipe_p0.err;
                    if (pipe_p0.valid) begin
                        pipe_p1.data <= pipe_p0.data;
                    end
                end
            end

            assign rd_out = pipe_p1;
        end else begin : g_no_out_reg
            assign rd_out = pipe_p0;
        end
    endgenerate

    assign RD_VALID = rd_out.valid;
    assign RD_ERR   = rd_out.err;
    assign RD_DATA  = rd_out.data;
    assign WR_ERR   = wr_err_p0;

endmodule
